icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Upstream write-side feeder for the icache tag/valid and data-bank simple dual-port RAMs (128 sets, 8 banks x 32 bits, 32-bit TAGV word).
- On a miss, it invalidates the set's tag, fetches one 256-bit line from memory as 8 sequential 32-bit beats, and writes each beat into its bank RAM.
- It then commits the tag/valid word and pulses refill_done with the packed 256-bit line for pipeline forwarding.

Parameters:
- INDEX_SIZE, 7, set index width (128 sets).
- TAG_SIZE, 20, tag width (addr[31:12]).
- OFFSET_SIZE, 5, byte offset within line.
- BANK_NUM, 8, words per line / bank RAM count.
- WORD_SIZE, 32, bank and beat data width.

Ports:
- clk  input  1  clock; drives all state and the RAM write ports.
- reset  input  1  synchronous active-high reset.
- miss_valid  input  1  icache miss request.
- miss_addr  input  32  missing instruction address.
- miss_ready  output  1  controller can accept a miss (IDLE only).
- rd_req  output  1  line read request to memory.
- rd_addr  output  32  line-aligned address {tag, index, 5'b0}.
- rd_ack  input  1  memory accepted the request.
- ret_valid  input  1  return beat valid.
- ret_last  input  1  final beat marker.
- ret_data  input  32  return beat data.
- bank_we  output  8  one-hot bank RAM write enable.
- bank_waddr  output  7  bank RAM write index.
- bank_wdata  output  32  bank RAM write data.
- tagv_we  output  1  tag/valid RAM write enable.
- tagv_waddr  output  7  tag/valid RAM write index.
- tagv_wdata  output  32  {11'b0, valid, tag[19:0]}.
- refill_done  output  1  1-cycle pulse: line committed.
- refill_err  output  1  1-cycle pulse: line aborted.
- refill_line  output  256  packed line; bank i at bits [32i+31:32i]; valid with refill_done.

Behaviour:
- Reset is synchronous and active-high. It forces state to IDLE and sets every output to 0, except miss_ready, which is 1 in IDLE. Beat counter, latched tag, latched index and line buffer all clear to 0.
- Reset mid-refill abandons the line with no further RAM writes. The set's tag is already invalid, so partial bank writes are harmless.
- States: IDLE, INVAL, REQ, RECV, COMMIT, ABORT.
- IDLE:
  - miss_ready=1.
  - On miss_valid, latch tag=miss_addr[31:12] and index=miss_addr[11:5], then go to INVAL.
- INVAL (1 cycle):
  - tagv_we=1, tagv_waddr=index, tagv_wdata={11'b0,1'b0,tag}.
  - Go to REQ.
- REQ:
  - rd_req=1 and rd_addr held stable until rd_ack is sampled high; then go to RECV with beat counter=0.
  - rd_req drops the cycle after the ack.
- RECV:
  - Each cycle with ret_valid: bank_we=1<<cnt, bank_waddr=index, bank_wdata=ret_data, buffer[cnt]=ret_data, cnt increments.
  - Bank writes are combinational from ret_valid in the same cycle (zero latency).
  - Beat with cnt==7: go to COMMIT. ret_last on that beat is expected but not required; extra beats afterwards are ignored.
  - ret_last with cnt<7: that beat is still written, then go to ABORT.
  - ret_valid outside RECV is ignored.
  - ret_valid before rd_ack is ignored.
- COMMIT (1 cycle):
  - tagv_we=1, tagv_wdata={11'b0,1'b1,tag}.
  - refill_done=1; refill_line=buffer.
  - Go to IDLE.
- ABORT (1 cycle):
  - refill_err=1, no tag write (set remains invalid).
  - Go to IDLE.
- Latency, with ack on the first REQ cycle and back-to-back beats: done asserts 11 cycles after miss acceptance (INVAL 1 + REQ 1 + 8 beats + COMMIT 1).
- A new miss is accepted only in IDLE. A miss_valid held across a refill is accepted the cycle the FSM returns to IDLE.
- bank_we, tagv_we, refill_done and refill_err are never high when their state conditions are false.
- At most one of tagv_we or bank_we is nonzero per cycle.
- Counter is 3 bits and saturates via the state exit; it never wraps into bank 0 within one refill.

Test Plan:
- Basic refill: miss_addr=0x0001_2340; ack immediately; 8 back-to-back beats 0xA0..0xA7 with last on beat 7. Required:
  - INVAL write to index 0x1A with tagv_wdata=0x0000_0012.
  - rd_addr=0x0001_2340.
  - bank_we 0x01..0x80 in order, bank_waddr=0x1A.
  - COMMIT tagv_wdata=0x0010_0012.
  - refill_line[31:0]=0xA0 and [255:224]=0xA7.
  - refill_done exactly 1 cycle, 11 cycles after miss acceptance.
- Stalled memory: rd_ack delayed 5 cycles, ret_valid gaps of 2 cycles between beats. Required:
  - rd_req and rd_addr stable until ack.
  - Bank writes only on valid cycles.
  - Final line correct.
- Early last: ret_last on beat 3. Required:
  - Banks 0..3 written.
  - refill_err pulses once.
  - No valid tag write; only the INVAL write is seen.
  - Back in IDLE with miss_ready=1.
- Missing last / extra beats: 10 beats, no ret_last. Required:
  - COMMIT after beat 7.
  - Beats 8..9 cause no bank_we.
- Reset mid-RECV after 4 beats. Required:
  - Next cycle all outputs 0, miss_ready=1.
  - A subsequent miss refills normally.
- Back-to-back misses: miss_valid held high with a second address. Required:
  - Second miss accepted the cycle after COMMIT.
  - Its INVAL targets the second index.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// ----------------------------------------------------------------------------
// icache_refill_ctrl_if
// Bundles the miss handshake, memory read channel, and RAM write ports of the
// icache refill controller.
//   master : the refill controller (drives miss_ready, rd_*, bank_*, tagv_*,
//            refill_*)
//   slave  : the surrounding pipeline / memory / RAM side
// Signals:
//   miss_valid/miss_addr/miss_ready     miss request handshake
//   rd_req/rd_addr/rd_ack               line read request to memory
//   ret_valid/ret_last/ret_data         returned beats
//   bank_we/bank_waddr/bank_wdata       data-bank RAM write port
//   tagv_we/tagv_waddr/tagv_wdata       tag/valid RAM write port
//   refill_done/refill_err/refill_line  completion pulses and forwarded line
// ----------------------------------------------------------------------------
interface icache_refill_ctrl_if #(
    parameter int unsigned INDEX_SIZE  = 7,
    parameter int unsigned TAG_SIZE    = 20,
    parameter int unsigned OFFSET_SIZE = 5,
    parameter int unsigned BANK_NUM    = 8,
    parameter int unsigned WORD_SIZE   = 32
);
    localparam int unsigned ADDR_SIZE = TAG_SIZE + INDEX_SIZE + OFFSET_SIZE;

    logic                            miss_valid;
    logic [ADDR_SIZE-1:0]            miss_addr;
    logic                            miss_ready;

    logic                            rd_req;
    logic [ADDR_SIZE-1:0]            rd_addr;
    logic                            rd_ack;

    logic                            ret_valid;
    logic                            ret_last;
    logic [WORD_SIZE-1:0]            ret_data;

    logic [BANK_NUM-1:0]             bank_we;
    logic [INDEX_SIZE-1:0]           bank_waddr;
    logic [WORD_SIZE-1:0]            bank_wdata;

    logic                            tagv_we;
    logic [INDEX_SIZE-1:0]           tagv_waddr;
    logic [WORD_SIZE-1:0]            tagv_wdata;

    logic                            refill_done;
    logic                            refill_err;
    logic [BANK_NUM*WORD_SIZE-1:0]   refill_line;

    modport master (
        input  miss_valid, miss_addr, rd_ack, ret_valid, ret_last, ret_data,
        output miss_ready, rd_req, rd_addr,
        output bank_we, bank_waddr, bank_wdata,
        output tagv_we, tagv_waddr, tagv_wdata,
        output refill_done, refill_err, refill_line
    );

    modport slave (
        output miss_valid, miss_addr, rd_ack, ret_valid, ret_last, ret_data,
        input  miss_ready, rd_req, rd_addr,
        input  bank_we, bank_waddr, bank_wdata,
        input  tagv_we, tagv_waddr, tagv_wdata,
        input  refill_done, refill_err, refill_line
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// icache_refill_ctrl
// Refills one icache line on a miss: invalidates the set's tag, requests the
// line from memory, writes each returned 32-bit beat straight into its bank
// RAM, then commits the valid tag and forwards the whole line to the pipeline.
// A premature ret_last aborts the refill, leaving the set invalid.
// Ports:
//   clk    clock for all state and the RAM write ports
//   reset  synchronous, active-high
//   bus    icache_refill_ctrl_if.master (miss handshake, memory read channel,
//          bank / tag-valid RAM write ports, done/err pulses and packed line)
// ----------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int unsigned INDEX_SIZE  = 7,
    parameter int unsigned TAG_SIZE    = 20,
    parameter int unsigned OFFSET_SIZE = 5,
    parameter int unsigned BANK_NUM    = 8,
    parameter int unsigned WORD_SIZE   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    icache_refill_ctrl_if.master        bus
);
    localparam int unsigned CNT_W     = $clog2(BANK_NUM);
    localparam int unsigned PAD_W     = WORD_SIZE - TAG_SIZE - 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BANK_NUM - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInval,
        StReq,
        StRecv,
        StCommit,
        StAbort
    } state_e;

    state_e                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [TAG_SIZE-1:0]                 tag_q, tag_d;
    logic [INDEX_SIZE-1:0]               index_q, index_d;
    logic [BANK_NUM-1:0][WORD_SIZE-1:0]  line_q, line_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tag_q   <= '0;
            index_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        index_d = index_q;
        line_d  = line_q;

        // Every output is gated by its state so nothing stale leaks out.
        bus.miss_ready  = 1'b0;
        bus.rd_req      = 1'b0;
        bus.rd_addr     = '0;
        bus.bank_we     = '0;
        bus.bank_waddr  = '0;
        bus.bank_wdata  = '0;
        bus.tagv_we     = 1'b0;
        bus.tagv_waddr  = '0;
        bus.tagv_wdata  = '0;
        bus.refill_done = 1'b0;
        bus.refill_err  = 1'b0;
        bus.refill_line = '0;

        unique case (state_q)
            StIdle: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    tag_d   = bus.miss_addr[OFFSET_SIZE+INDEX_SIZE +: TAG_SIZE];
                    index_d = bus.miss_addr[OFFSET_SIZE +: INDEX_SIZE];
                    state_d = StInval;
                end
            end
            StInval: begin
                // Kill the old tag first so partial bank writes are never hit.
                bus.tagv_we    = 1'b1;
                bus.tagv_waddr = index_q;
                bus.tagv_wdata = {{PAD_W{1'b0}}, 1'b0, tag_q};
                state_d        = StReq;
            end
            StReq: begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = {tag_q, index_q, {OFFSET_SIZE{1'b0}}};
                if (bus.rd_ack) begin
                    cnt_d   = '0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (bus.ret_valid) begin
                    bus.bank_we        = BANK_NUM'(1) << cnt_q;
                    bus.bank_waddr     = index_q;
                    bus.bank_wdata     = bus.ret_data;
                    line_d[cnt_q]      = bus.ret_data;
                    cnt_d              = cnt_q + CNT_W'(1);
                    // The counter beat decides completion; ret_last only
                    // matters when it arrives early.
                    if (cnt_q == LAST_BEAT) begin
                        state_d = StCommit;
                    end else if (bus.ret_last) begin
                        state_d = StAbort;
                    end
                end
            end
            StCommit: begin
                bus.tagv_we     = 1'b1;
                bus.tagv_waddr  = index_q;
                bus.tagv_wdata  = {{PAD_W{1'b0}}, 1'b1, tag_q};
                bus.refill_done = 1'b1;
                bus.refill_line = line_q;
                state_d         = StIdle;
            end
            StAbort: begin
                bus.refill_err = 1'b1;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    icache_refill_ctrl_if bus ();

    icache_refill_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.miss_valid = 1'b0;
        bus.miss_addr  = '0;
        bus.rd_ack     = 1'b0;
        bus.ret_valid  = 1'b0;
        bus.ret_last   = 1'b0;
        bus.ret_data   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready: got %0h want 1", bus.miss_ready); end
        checks++; if ({bus.rd_req, bus.tagv_we, bus.refill_done, bus.refill_err} !== 4'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 0000", {bus.rd_req, bus.tagv_we, bus.refill_done, bus.refill_err}); end
        checks++; if (bus.bank_we !== 8'h00) begin errors++; $display("FAIL rst_bank_we: got %0h want 0", bus.bank_we); end
        checks++; if (bus.rd_addr !== 32'h0) begin errors++; $display("FAIL rst_rd_addr: got %0h want 0", bus.rd_addr); end
        checks++; if (bus.refill_line !== 256'h0) begin errors++; $display("FAIL rst_line: got %0h want 0", bus.refill_line); end
        reset = 1'b0;
    endtask

    // Full refill with immediate ack and back-to-back beats base..base+7.
    task automatic run_refill(input logic [31:0] addr, input logic [31:0] base,
                              input logic [6:0] exp_idx, input logic [31:0] exp_inval,
                              input logic [31:0] exp_commit);
        int cyc;
        int n;
        @(negedge clk); bus.miss_valid = 1'b1; bus.miss_addr = addr; #1;
        checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL rf_accept: got %0h want 1", bus.miss_ready); end
        @(negedge clk); bus.miss_valid = 1'b0; #1; cyc = 1;
        checks++; if (bus.tagv_we !== 1'b1 || bus.tagv_waddr !== exp_idx) begin errors++; $display("FAIL rf_inval_addr: got we=%0h idx=%0h want we=1 idx=%0h", bus.tagv_we, bus.tagv_waddr, exp_idx); end
        checks++; if (bus.tagv_wdata !== exp_inval) begin errors++; $display("FAIL rf_inval_data: got %0h want %0h", bus.tagv_wdata, exp_inval); end
        @(negedge clk); bus.rd_ack = 1'b1; #1; cyc++;
        checks++; if (bus.rd_req !== 1'b1 || bus.rd_addr !== {addr[31:5], 5'b0}) begin errors++; $display("FAIL rf_req: got req=%0h addr=%0h want req=1 addr=%0h", bus.rd_req, bus.rd_addr, {addr[31:5], 5'b0}); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.rd_ack = 1'b0; bus.ret_valid = 1'b1; bus.ret_data = base + 32'(i);
            bus.ret_last = (i == 7); #1; cyc++;
            checks++; if (bus.bank_we !== (8'h01 << i) || bus.bank_waddr !== exp_idx || bus.bank_wdata !== base + 32'(i)) begin errors++; $display("FAIL rf_beat%0d: got we=%0h idx=%0h d=%0h want we=%0h idx=%0h d=%0h", i, bus.bank_we, bus.bank_waddr, bus.bank_wdata, 8'h01 << i, exp_idx, base + 32'(i)); end
        end
        @(negedge clk); bus.ret_valid = 1'b0; bus.ret_last = 1'b0; #1; cyc++;
        n = 0;
        while (bus.refill_done !== 1'b1 && n < 4) begin @(negedge clk); #1; cyc++; n++; end
        checks++; if (cyc !== 11) begin errors++; $display("FAIL rf_latency: got %0d want 11", cyc); end
        checks++; if (bus.tagv_we !== 1'b1 || bus.tagv_waddr !== exp_idx || bus.tagv_wdata !== exp_commit) begin errors++; $display("FAIL rf_commit: got we=%0h idx=%0h d=%0h want we=1 idx=%0h d=%0h", bus.tagv_we, bus.tagv_waddr, bus.tagv_wdata, exp_idx, exp_commit); end
        checks++; if (bus.refill_line[31:0] !== base || bus.refill_line[255:224] !== base + 32'd7) begin errors++; $display("FAIL rf_line: got lo=%0h hi=%0h want lo=%0h hi=%0h", bus.refill_line[31:0], bus.refill_line[255:224], base, base + 32'd7); end
        @(negedge clk); #1;
        checks++; if (bus.refill_done !== 1'b0 || bus.miss_ready !== 1'b1) begin errors++; $display("FAIL rf_after: got done=%0h ready=%0h want done=0 ready=1", bus.refill_done, bus.miss_ready); end
    endtask

    task automatic test_basic();
        run_refill(32'h0001_2340, 32'h0000_00A0, 7'h1A, 32'h0000_0012, 32'h0010_0012);
    endtask

    task automatic test_stall();
        logic [255:0] exp_line;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h1000 + 32'(i);
        @(negedge clk); bus.miss_valid = 1'b1; bus.miss_addr = 32'h8000_0FE0;
        @(negedge clk); bus.miss_valid = 1'b0; #1;
        checks++; if (bus.tagv_waddr !== 7'h7F || bus.tagv_wdata !== 32'h0008_0000) begin errors++; $display("FAIL st_inval: got idx=%0h d=%0h want idx=7f d=80000", bus.tagv_waddr, bus.tagv_wdata); end
        // Beats presented before the ack must be ignored.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); bus.ret_valid = 1'b1; bus.ret_data = 32'hDEAD; #1;
            checks++; if ({bus.rd_req, bus.rd_addr, bus.bank_we} !== {1'b1, 32'h8000_0FE0, 8'h00}) begin errors++; $display("FAIL st_wait%0d: got req=%0h addr=%0h we=%0h want req=1 addr=80000fe0 we=0", k, bus.rd_req, bus.rd_addr, bus.bank_we); end
        end
        @(negedge clk); bus.ret_valid = 1'b0; bus.rd_ack = 1'b1; #1;
        checks++; if (bus.rd_req !== 1'b1 || bus.rd_addr !== 32'h8000_0FE0) begin errors++; $display("FAIL st_ack: got req=%0h addr=%0h want req=1 addr=80000fe0", bus.rd_req, bus.rd_addr); end
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 2; g++) begin
                @(negedge clk); bus.rd_ack = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; #1;
                checks++; if (bus.bank_we !== 8'h00 || bus.rd_req !== 1'b0) begin errors++; $display("FAIL st_gap%0d: got we=%0h req=%0h want we=0 req=0", i, bus.bank_we, bus.rd_req); end
            end
            @(negedge clk); bus.ret_valid = 1'b1; bus.ret_data = 32'h1000 + 32'(i); bus.ret_last = (i == 7); #1;
            checks++; if (bus.bank_we !== (8'h01 << i) || bus.bank_wdata !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL st_beat%0d: got we=%0h d=%0h want we=%0h d=%0h", i, bus.bank_we, bus.bank_wdata, 8'h01 << i, 32'h1000 + 32'(i)); end
        end
        @(negedge clk); bus.ret_valid = 1'b0; bus.ret_last = 1'b0; #1;
        checks++; if (bus.refill_done !== 1'b1 || bus.tagv_wdata !== 32'h0018_0000) begin errors++; $display("FAIL st_commit: got done=%0h d=%0h want done=1 d=180000", bus.refill_done, bus.tagv_wdata); end
        checks++; if (bus.refill_line !== exp_line) begin errors++; $display("FAIL st_line: got %0h want %0h", bus.refill_line, exp_line); end
    endtask

    task automatic test_early_last();
        int tv = 0;
        int er = 0;
        @(negedge clk); bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_0040;
        @(negedge clk); bus.miss_valid = 1'b0; #1; tv += int'(bus.tagv_we);
        checks++; if (bus.tagv_waddr !== 7'h02 || bus.tagv_wdata !== 32'h0) begin errors++; $display("FAIL el_inval: got idx=%0h d=%0h want idx=2 d=0", bus.tagv_waddr, bus.tagv_wdata); end
        @(negedge clk); bus.rd_ack = 1'b1; #1; tv += int'(bus.tagv_we);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.rd_ack = 1'b0; bus.ret_valid = 1'b1; bus.ret_data = 32'hE0 + 32'(i); bus.ret_last = (i == 3); #1;
            tv += int'(bus.tagv_we);
            checks++; if (bus.bank_we !== (8'h01 << i) || bus.bank_waddr !== 7'h02) begin errors++; $display("FAIL el_beat%0d: got we=%0h idx=%0h want we=%0h idx=2", i, bus.bank_we, bus.bank_waddr, 8'h01 << i); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus.ret_valid = 1'b0; bus.ret_last = 1'b0; #1;
            tv += int'(bus.tagv_we); er += int'(bus.refill_err);
            checks++; if (bus.refill_done !== 1'b0) begin errors++; $display("FAIL el_done%0d: got %0h want 0", k, bus.refill_done); end
            if (k == 0) begin
                checks++; if (bus.refill_err !== 1'b1) begin errors++; $display("FAIL el_err: got %0h want 1", bus.refill_err); end
            end
        end
        checks++; if (er !== 1) begin errors++; $display("FAIL el_err_count: got %0d want 1", er); end
        checks++; if (tv !== 1) begin errors++; $display("FAIL el_tagv_count: got %0d want 1", tv); end
        checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL el_ready: got %0h want 1", bus.miss_ready); end
    endtask

    task automatic test_extra_beats();
        @(negedge clk); bus.miss_valid = 1'b1; bus.miss_addr = 32'h1234_5678;
        @(negedge clk); bus.miss_valid = 1'b0; #1;
        checks++; if (bus.tagv_waddr !== 7'h33) begin errors++; $display("FAIL xb_inval: got %0h want 33", bus.tagv_waddr); end
        @(negedge clk); bus.rd_ack = 1'b1; #1;
        checks++; if (bus.rd_addr !== 32'h1234_5660) begin errors++; $display("FAIL xb_addr: got %0h want 12345660", bus.rd_addr); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus.rd_ack = 1'b0; bus.ret_valid = 1'b1; bus.ret_data = 32'h5550 + 32'(i); #1;
            if (i < 8) begin
                checks++; if (bus.bank_we !== (8'h01 << i)) begin errors++; $display("FAIL xb_beat%0d: got %0h want %0h", i, bus.bank_we, 8'h01 << i); end
            end else begin
                checks++; if (bus.bank_we !== 8'h00) begin errors++; $display("FAIL xb_extra%0d: got %0h want 0", i, bus.bank_we); end
            end
            if (i == 8) begin
                checks++; if (bus.refill_done !== 1'b1 || bus.tagv_wdata !== 32'h0011_2345) begin errors++; $display("FAIL xb_commit: got done=%0h d=%0h want done=1 d=112345", bus.refill_done, bus.tagv_wdata); end
            end
            if (i == 9) begin
                checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL xb_idle: got %0h want 1", bus.miss_ready); end
            end
        end
        @(negedge clk); bus.ret_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_1000;
        @(negedge clk); bus.miss_valid = 1'b0;
        @(negedge clk); bus.rd_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.rd_ack = 1'b0; bus.ret_valid = 1'b1; bus.ret_data = 32'h7700 + 32'(i);
        end
        @(negedge clk); reset = 1'b1; bus.ret_data = 32'h7704;
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %0h want 1", bus.miss_ready); end
        checks++; if ({bus.rd_req, bus.tagv_we, bus.refill_done, bus.refill_err, bus.bank_we} !== 12'h000) begin errors++; $display("FAIL rm_ctrl: got %0h want 0", {bus.rd_req, bus.tagv_we, bus.refill_done, bus.refill_err, bus.bank_we}); end
        checks++; if ({bus.rd_addr, bus.tagv_waddr, bus.bank_waddr, bus.tagv_wdata, bus.bank_wdata} !== 110'h0 || bus.refill_line !== 256'h0) begin errors++; $display("FAIL rm_data: got addr=%0h line=%0h want 0", bus.rd_addr, bus.refill_line); end
        bus.ret_valid = 1'b0;
        run_refill(32'h0000_2020, 32'h0000_00B0, 7'h01, 32'h0000_0002, 32'h0010_0002);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_3060;
        @(negedge clk); bus.miss_addr = 32'h0000_4100; #1;
        checks++; if (bus.tagv_waddr !== 7'h03 || bus.miss_ready !== 1'b0) begin errors++; $display("FAIL bb_inval_a: got idx=%0h ready=%0h want idx=3 ready=0", bus.tagv_waddr, bus.miss_ready); end
        @(negedge clk); bus.rd_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); bus.rd_ack = 1'b0; bus.ret_valid = 1'b1; bus.ret_data = 32'hC0 + 32'(i); bus.ret_last = (i == 7);
        end
        @(negedge clk); bus.ret_valid = 1'b0; bus.ret_last = 1'b0; #1;
        checks++; if (bus.refill_done !== 1'b1 || bus.miss_ready !== 1'b0) begin errors++; $display("FAIL bb_commit_a: got done=%0h ready=%0h want done=1 ready=0", bus.refill_done, bus.miss_ready); end
        @(negedge clk); #1;
        checks++; if (bus.miss_ready !== 1'b1 || bus.tagv_we !== 1'b0) begin errors++; $display("FAIL bb_idle: got ready=%0h we=%0h want ready=1 we=0", bus.miss_ready, bus.tagv_we); end
        @(negedge clk); bus.miss_valid = 1'b0; #1;
        checks++; if (bus.tagv_we !== 1'b1 || bus.tagv_waddr !== 7'h08 || bus.tagv_wdata !== 32'h0000_0004) begin errors++; $display("FAIL bb_inval_b: got we=%0h idx=%0h d=%0h want we=1 idx=8 d=4", bus.tagv_we, bus.tagv_waddr, bus.tagv_wdata); end
        @(negedge clk); bus.rd_ack = 1'b1; #1;
        checks++; if (bus.rd_addr !== 32'h0000_4100) begin errors++; $display("FAIL bb_addr_b: got %0h want 4100", bus.rd_addr); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); bus.rd_ack = 1'b0; bus.ret_valid = 1'b1; bus.ret_data = 32'hD0 + 32'(i); bus.ret_last = (i == 7);
        end
        @(negedge clk); bus.ret_valid = 1'b0; bus.ret_last = 1'b0; #1;
        checks++; if (bus.refill_done !== 1'b1 || bus.tagv_wdata !== 32'h0010_0004 || bus.refill_line[255:224] !== 32'hD7) begin errors++; $display("FAIL bb_commit_b: got done=%0h d=%0h hi=%0h want done=1 d=100004 hi=d7", bus.refill_done, bus.tagv_wdata, bus.refill_line[255:224]); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_early_last();
        test_extra_beats();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
